// File: rtl/board_pkg.sv
// Shared board definitions: register-bank port widths and debounce FSM encoding.
package board_pkg;

    localparam int unsigned BIT_ADDR_DEF = 2;
    localparam int unsigned BIT_DATO_DEF = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

endpackage

// File: rtl/button_write_strobe_if.sv
// Button/switch inputs and register-bank write port of the input conditioner.
interface button_write_strobe_if #(
    parameter int unsigned BIT_ADDR = 2,
    parameter int unsigned BIT_DATO = 4
) ();

    logic                         btn_raw;
    logic [BIT_ADDR+BIT_DATO-1:0] sw_raw;
    logic                         RegWrite;
    logic [BIT_ADDR-1:0]          addrW;
    logic [BIT_DATO-1:0]          datW;
    logic                         btn_level;

    // Board side: drives the raw inputs, observes the write port
    modport master (
        output btn_raw, sw_raw,
        input  RegWrite, addrW, datW, btn_level
    );

    // Conditioner side
    modport slave (
        input  btn_raw, sw_raw,
        output RegWrite, addrW, datW, btn_level
    );

endinterface

// File: rtl/debounce_filter.sv
// Synchronise, polarity-normalise and debounce one push-button.
// level: debounced press level; rise_c: one-cycle pulse on the cycle a press is accepted.
module debounce_filter
    import board_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter bit          BTN_ACT_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise_c
);

    localparam int unsigned     CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic            REL_LVL  = BTN_ACT_LOW;

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    deb_state_e       state_q, state_d;
    logic             level_q, level_d;
    logic             pressed_c;

    assign pressed_c = sync_q[1] ^ BTN_ACT_LOW;
    assign level     = level_q;

    // Next-state, counter and strobe decode
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed_c) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_c) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    rise_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed_c) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_c) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // State, counter and synchroniser registers; synchroniser clears to released level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= {2{REL_LVL}};
            cnt_q   <= '0;
            state_q <= IDLE;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/button_write_strobe.sv
// Write-button conditioner for the 4x4 register bank: one strobe per press,
// address/data switches captured on the strobe edge and held until the next one.
module button_write_strobe
    import board_pkg::*;
#(
    parameter int unsigned BIT_ADDR    = BIT_ADDR_DEF,
    parameter int unsigned BIT_DATO    = BIT_DATO_DEF,
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter bit          BTN_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    button_write_strobe_if.slave  bus
);

    localparam int unsigned SW_W = BIT_ADDR + BIT_DATO;

    logic [SW_W-1:0]     sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]     sw_sync_q, sw_sync_d;
    logic                reg_write_q, reg_write_d;
    logic [BIT_ADDR-1:0] addr_q, addr_d;
    logic [BIT_DATO-1:0] dat_q, dat_d;
    logic                btn_level;
    logic                strobe_c;

    debounce_filter #(
        .DEB_CYCLES  (DEB_CYCLES),
        .BTN_ACT_LOW (BTN_ACT_LOW)
    ) u_btn_filter (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_raw),
        .level   (btn_level),
        .rise_c  (strobe_c)
    );

    assign bus.RegWrite  = reg_write_q;
    assign bus.addrW     = addr_q;
    assign bus.datW      = dat_q;
    assign bus.btn_level = btn_level;

    // Switch synchroniser and capture on the accepted-press cycle
    always_comb begin
        sw_meta_d   = bus.sw_raw;
        sw_sync_d   = sw_meta_q;
        reg_write_d = strobe_c;
        addr_d      = addr_q;
        dat_d       = dat_q;
        if (strobe_c) begin
            addr_d = sw_sync_q[BIT_ADDR-1:0];
            dat_d  = sw_sync_q[SW_W-1:BIT_ADDR];
        end
    end

    // Output and synchroniser registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            reg_write_q <= 1'b0;
            addr_q      <= '0;
            dat_q       <= '0;
        end else begin
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            reg_write_q <= reg_write_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
        end
    end

endmodule
